// File: rtl/fb_pkg.sv
// Shared types for the frame-buffer raster-scan read path.
//   state_t     : controller state (IDLE / SCAN / DRAIN)
//   FIFO_DEPTH  : entries in the output skid FIFO
//   pix_flags_t : per-pixel frame/line markers carried alongside each pixel
package fb_pkg;
   typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;
   localparam int FIFO_DEPTH = 2;
   typedef struct packed {
      logic sof;
      logic eof;
      logic sol;
      logic eol;
   } pix_flags_t;
endpackage

// File: rtl/fb_scan_rd_if.sv
// Bus bundle between the scan controller, the frame memory read port and
// the pixel stream sink.
//   master : the scan controller (drives read strobe/address and pixel stream)
//   slave  : memory + display side (returns read data and pix_ready)
interface fb_scan_rd_if #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 5
);
   import fb_pkg::*;
   logic                  mem_rd_en;
   logic [ADDR_WIDTH-1:0] mem_rd_addr;
   logic [DATA_WIDTH-1:0] mem_rd_data;
   logic [DATA_WIDTH-1:0] pix_data;
   logic                  pix_valid;
   logic                  pix_ready;
   logic                  pix_sof;
   logic                  pix_eof;
   logic                  pix_sol;
   logic                  pix_eol;

   modport master (
      output mem_rd_en, mem_rd_addr, pix_data, pix_valid,
             pix_sof, pix_eof, pix_sol, pix_eol,
      input  mem_rd_data, pix_ready
   );
   modport slave (
      input  mem_rd_en, mem_rd_addr, pix_data, pix_valid,
             pix_sof, pix_eof, pix_sol, pix_eol,
      output mem_rd_data, pix_ready
   );
endinterface

// File: rtl/fb_skid_fifo.sv
// Two-entry FIFO with a registered head: dout comes straight from a flop,
// the second entry only fills while the head is stalled.
// Ports: clk, reset (async active-low), push/din, pop, dout, count, empty, full.
// Caller must not push when full without a simultaneous pop, nor pop when empty.
module fb_skid_fifo
   import fb_pkg::*;
#(
   parameter int WIDTH = 20
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            push,
   input  logic                            pop,
   input  logic [WIDTH-1:0]                din,
   output logic [WIDTH-1:0]                dout,
   output logic [$clog2(FIFO_DEPTH+1)-1:0] count,
   output logic                            empty,
   output logic                            full
);
   localparam int CW = $clog2(FIFO_DEPTH+1);

   logic [WIDTH-1:0] head, tail;
   logic [CW-1:0]    cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head <= '0;
         tail <= '0;
         cnt  <= '0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (cnt == '0) head <= din;
               else           tail <= din;
               cnt <= cnt + CW'(1);
            end
            2'b01: begin
               if (cnt == CW'(2)) head <= tail;
               cnt <= cnt - CW'(1);
            end
            2'b11: begin
               // occupancy unchanged; the new word goes behind whatever remains
               if (cnt == CW'(1)) head <= din;
               else begin
                  head <= tail;
                  tail <= din;
               end
            end
            default: ;
         endcase
      end
   end

   assign dout  = head;
   assign count = cnt;
   assign empty = (cnt == '0);
   assign full  = (cnt == CW'(FIFO_DEPTH));
endmodule

// File: rtl/fb_scan_rd.sv
// Raster-scan read controller for the frame-buffer data memory.
// Issues sequential reads for one frame, absorbs the 1-cycle memory read
// latency, and streams pixels with sof/eof/sol/eol markers through a
// 2-entry skid FIFO so downstream backpressure never drops a pixel.
// Ports: clk, reset (async active-low), start, busy, done, bus (master side:
// mem_rd_en/mem_rd_addr/mem_rd_data, pix_data/valid/ready + flags).
// Build option: FB_SCAN_RD_CONT_EN selects continuous frame scanning
// (restart on the last read with no bubble) instead of single-frame mode.
module fb_scan_rd
   import fb_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 5,
   parameter int FRAME_W    = 8,
   parameter int FRAME_H    = 4,
   parameter int BASE_ADDR  = 0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   output logic         busy,
   output logic         done,
   fb_scan_rd_if.master bus
);
   localparam int XW = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
   localparam int YW = (FRAME_H > 1) ? $clog2(FRAME_H) : 1;
   localparam int CW = $clog2(FIFO_DEPTH+1);
   localparam logic [XW-1:0]         X_LAST = XW'(FRAME_W-1);
   localparam logic [YW-1:0]         Y_LAST = YW'(FRAME_H-1);
   localparam logic [ADDR_WIDTH-1:0] ADDR0  = ADDR_WIDTH'(BASE_ADDR);

   state_t                  state, state_nx;
   logic [XW-1:0]           x;
   logic [YW-1:0]           y;
   logic [ADDR_WIDTH-1:0]   addr;
   logic                    inflight;
   pix_flags_t              cur_flags, rd_flags, head_flags;
   logic [DATA_WIDTH+3:0]   fifo_dout;
   logic [CW-1:0]           fifo_cnt;
   logic                    fifo_empty, fifo_full;
   logic                    pop, push, issue, last_rd;

   assign pop = !fifo_empty && bus.pix_ready;

   // Occupancy after this cycle's pop, counting the read still in flight,
   // must leave room for one more word.
   assign issue   = (state == SCAN) &&
                    (({1'b0, fifo_cnt} + 3'(inflight) - 3'(pop)) < 3'd2);
   assign last_rd = issue && (x == X_LAST) && (y == Y_LAST);

   always_comb begin
      cur_flags     = '0;
      cur_flags.sof = (x == '0) && (y == '0);
      cur_flags.eof = (x == X_LAST) && (y == Y_LAST);
      cur_flags.sol = (x == '0);
      cur_flags.eol = (x == X_LAST);
   end

   assign head_flags = pix_flags_t'(fifo_dout[DATA_WIDTH+3:DATA_WIDTH]);
   assign done       = pop && head_flags.eof;

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:  if (start) state_nx = SCAN;
`ifndef FB_SCAN_RD_CONT_EN
         SCAN:  if (last_rd) state_nx = DRAIN;
`endif
         DRAIN: if (done) state_nx = IDLE;
         default: state_nx = state;
      endcase
   end

`ifdef FB_SCAN_RD_CONT_EN
   assign busy = (state != IDLE);
`else
   // drops together with done so the two never overlap
   assign busy = (state != IDLE) && !((state == DRAIN) && done);
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         x        <= '0;
         y        <= '0;
         addr     <= ADDR0;
         inflight <= 1'b0;
         rd_flags <= '0;
      end else begin
         state    <= state_nx;
         inflight <= issue;
         if (issue) begin
            rd_flags <= cur_flags;
            // counters reload on the last read so the next frame (or the
            // next start) begins at pixel (0,0)
            if (last_rd) begin
               x    <= '0;
               y    <= '0;
               addr <= ADDR0;
            end else begin
               addr <= addr + ADDR_WIDTH'(1);
               if (x == X_LAST) begin
                  x <= '0;
                  y <= y + YW'(1);
               end else begin
                  x <= x + XW'(1);
               end
            end
         end
      end
   end

   // the read returns one cycle after issue; its flags were parked in rd_flags
   assign push = inflight && (!fifo_full || pop);

   fb_skid_fifo #(.WIDTH(DATA_WIDTH+4)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   ({rd_flags, bus.mem_rd_data}),
      .dout  (fifo_dout),
      .count (fifo_cnt),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

   assign bus.mem_rd_en   = issue;
   assign bus.mem_rd_addr = addr;
   assign bus.pix_valid   = !fifo_empty;
   assign bus.pix_data    = fifo_dout[DATA_WIDTH-1:0];
   assign bus.pix_sof     = !fifo_empty && head_flags.sof;
   assign bus.pix_eof     = !fifo_empty && head_flags.eof;
   assign bus.pix_sol     = !fifo_empty && head_flags.sol;
   assign bus.pix_eol     = !fifo_empty && head_flags.eol;
endmodule

// File: tb/tb_fb_scan_rd.sv
module tb_fb_scan_rd;
   import fb_pkg::*;
   localparam int DW = 16, AW = 5, W = 4, H = 2, BASE = 4;

   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
   logic busy, done;
   fb_scan_rd_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   fb_scan_rd #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FRAME_W(W), .FRAME_H(H),
                .BASE_ADDR(BASE)) dut (
      .clk(clk), .reset(rst_n), .start(start), .busy(busy), .done(done), .bus(bus)
   );

   always #5 clk = ~clk;

   // frame memory model: word at address a is 16'h0100 + a, 1-cycle latency
   initial bus.mem_rd_data = '0;
   always @(posedge clk) if (bus.mem_rd_en) bus.mem_rd_data <= 16'h0100 + 16'(bus.mem_rd_addr);

   typedef struct {
      logic [15:0] d;
      logic [3:0]  f;   // {sof, eof, sol, eol}
   } pix_t;
   pix_t exp_q[$];
   int   exp_a[$];
   int   total = 0, bad = 0;
   int   nacc = 0, ndone = 0, occ = 0;

   function automatic void chk(input string nm, input logic [31:0] a, input logic [31:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h @%0t", nm, a, e, $time);
      end
   endfunction

   // hand-derived frame for W=4,H=2,BASE=4: pixels 0104..010B
   task automatic push_frame();
      for (int yy = 0; yy < H; yy++)
         for (int xx = 0; xx < W; xx++) begin
            pix_t p;
            p.d = 16'h0100 + 16'(BASE + yy*W + xx);
            p.f = {(xx == 0 && yy == 0), (xx == W-1 && yy == H-1), (xx == 0), (xx == W-1)};
            exp_q.push_back(p);
            exp_a.push_back(BASE + yy*W + xx);
         end
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic wait_idle(input string nm);
      int k;
      k = 0;
      while (busy && k < 200) begin @(negedge clk); k++; end
      if (k >= 200) chk({nm, "_timeout"}, 1, 0);
      repeat (3) @(negedge clk);
   endtask

   // monitor / scoreboard
   initial begin
      logic        prev_stall;
      logic [15:0] prev_data;
      prev_stall = 1'b0;
      prev_data  = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_stall = 1'b0;
            occ = 0;
         end else begin
            logic pop, exp_done;
            pop = bus.pix_valid && bus.pix_ready;
            exp_done = 1'b0;
            if (prev_stall) begin
               chk("stall_valid", 32'(bus.pix_valid), 1);
               chk("stall_data", 32'(bus.pix_data), 32'(prev_data));
            end
            if (bus.mem_rd_en) begin
               chk("issue_rule", 32'((occ - int'(pop)) < 2), 1);
               if (exp_a.size() == 0) chk("rd_unexpected", 1, 0);
               else chk("rd_addr", 32'(bus.mem_rd_addr), 32'(exp_a.pop_front()));
            end
            if (pop) begin
               if (exp_q.size() == 0) chk("pix_unexpected", 32'(bus.pix_data), 0);
               else begin
                  pix_t e;
                  e = exp_q.pop_front();
                  chk("pix_data", 32'(bus.pix_data), 32'(e.d));
                  chk("pix_flags", 32'({bus.pix_sof, bus.pix_eof, bus.pix_sol, bus.pix_eol}), 32'(e.f));
                  exp_done = e.f[2];
               end
               nacc++;
            end
            if (done !== exp_done) chk("done", 32'(done), 32'(exp_done));
            if (done) ndone++;
            occ = occ + int'(bus.mem_rd_en) - int'(pop);
            prev_stall = bus.pix_valid && !bus.pix_ready;
            prev_data  = bus.pix_data;
         end
      end
   end

   initial begin
      bus.pix_ready = 1'b1;
      // 1: reset and idle
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", 32'(bus.pix_valid), 0);
      chk("rst_addr", 32'(bus.mem_rd_addr), BASE);
      #1 rst_n = 1'b1;
      begin
         int act;
         act = 0;
         repeat (5) begin
            @(negedge clk);
            act += int'(bus.mem_rd_en) + int'(bus.pix_valid) + int'(busy) + int'(done);
         end
         chk("idle_activity", 32'(act), 0);
         chk("idle_addr", 32'(bus.mem_rd_addr), BASE);
         chk("idle_data", 32'(bus.pix_data), 0);
         chk("idle_flags", 32'({bus.pix_sof, bus.pix_eof, bus.pix_sol, bus.pix_eol}), 0);
      end

`ifdef FB_SCAN_RD_CONT_EN
      // 6: continuous mode, three frames back-to-back
      begin
         int gaps, busy_lo, first_v, last_d, bad_gap, k;
         gaps = 0; busy_lo = 0; first_v = 0; last_d = 0; bad_gap = 0; k = 0;
         repeat (3) push_frame();
         for (int i = 0; i < W*H; i++) exp_a.push_back(BASE + i);
         pulse_start();
         while (k < 100) begin
            @(negedge clk); k++;
            if (nacc < 3*W*H) begin
               if (!busy) busy_lo++;
               if (bus.pix_valid) first_v = 1;
               else if (first_v != 0) gaps++;
               if (done) begin
                  if (last_d != 0 && k - last_d != W*H) bad_gap++;
                  last_d = k;
               end
            end
            @(posedge clk); #1;
            if (nacc >= 3*W*H) begin bus.pix_ready = 1'b0; break; end
         end
         chk("cont_timeout", 32'(k < 100), 1);
         chk("cont_busy_low", 32'(busy_lo), 0);
         chk("cont_gaps", 32'(gaps), 0);
         chk("cont_done_period", 32'(bad_gap), 0);
         chk("cont_ndone", 32'(ndone), 3);
         chk("cont_q_left", 32'(exp_q.size()), 0);
      end
`else
      // 2: latency, throughput, flags, done timing
      begin
         int first_en, en_n, first_v, done_k, busy1, busy_d;
         first_en = 0; en_n = 0; first_v = 0; done_k = 0; busy1 = 0; busy_d = 1;
         push_frame();
         @(posedge clk); #1 start = 1'b1;
         @(posedge clk); #1 start = 1'b0;   // that edge is N
         for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (bus.mem_rd_en) begin en_n++; if (first_en == 0) first_en = k; end
            if (bus.pix_valid && first_v == 0) first_v = k;
            if (done) begin done_k = k; busy_d = int'(busy); end
            if (k == 1) busy1 = int'(busy);
         end
         chk("t2_first_rd", 32'(first_en), 1);
         chk("t2_rd_count", 32'(en_n), W*H);
         chk("t2_first_pix", 32'(first_v), 3);
         chk("t2_done_cycle", 32'(done_k), 10);
         chk("t2_busy_start", 32'(busy1), 1);
         chk("t2_busy_at_done", 32'(busy_d), 0);
         chk("t2_q_left", 32'(exp_q.size()), 0);
      end

      // 3: backpressure pattern 1,0,0,1
      begin
         int k, d0;
         logic pat[4];
         pat = '{1'b1, 1'b0, 1'b0, 1'b1};
         d0 = ndone; k = 0;
         push_frame();
         pulse_start();
         while (k < 200) begin
            @(posedge clk); #1 bus.pix_ready = pat[k % 4];
            @(negedge clk); k++;
            if (!busy) break;
         end
         bus.pix_ready = 1'b1;
         chk("t3_timeout", 32'(k < 200), 1);
         repeat (3) @(negedge clk);
         chk("t3_q_left", 32'(exp_q.size()), 0);
         chk("t3_ndone", 32'(ndone - d0), 1);
      end

      // 4: start while busy is ignored
      begin
         int d0;
         d0 = ndone;
         push_frame();
         pulse_start();
         repeat (3) @(negedge clk);
         pulse_start();
         wait_idle("t4");
         chk("t4_ndone", 32'(ndone - d0), 1);
         chk("t4_q_left", 32'(exp_q.size()), 0);
         chk("t4_a_left", 32'(exp_a.size()), 0);
         chk("t4_busy", 32'(busy), 0);
      end

      // 5: reset while pixel 0106 is on the output
      begin
         int k, d0;
         k = 0;
         push_frame();
         pulse_start();
         while (k < 50) begin
            @(negedge clk); k++;
            if (bus.pix_valid && bus.pix_data == 16'h0106) break;
         end
         chk("t5_reach_0106", 32'(k < 50), 1);
         rst_n = 1'b0;
         #1;
         chk("t5_rst_valid", 32'(bus.pix_valid), 0);
         chk("t5_rst_data", 32'(bus.pix_data), 0);
         chk("t5_rst_addr", 32'(bus.mem_rd_addr), BASE);
         chk("t5_rst_ctrl", 32'({busy, done, bus.mem_rd_en, bus.pix_sof}), 0);
         exp_q.delete();
         exp_a.delete();
         repeat (2) @(posedge clk);
         #1 rst_n = 1'b1;
         d0 = ndone;
         push_frame();
         pulse_start();
         wait_idle("t5");
         chk("t5_ndone", 32'(ndone - d0), 1);
         chk("t5_q_left", 32'(exp_q.size()), 0);
      end
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/fb_scan_rd.md
Name: fb_scan_rd

Overview:
- Raster-scan read controller sitting directly downstream of the frame-buffer data memory (`data_mem_alt`).
- Generates sequential read addresses for one frame and absorbs the memory's 1-cycle read latency.
- Delivers pixels as a valid/ready stream with start/end-of-line and start/end-of-frame flags to the display/output stage.
- Absorbs downstream backpressure with a 2-entry skid FIFO, so no pixel is ever dropped or duplicated.

Parameters:
- DATA_WIDTH, 16, pixel/memory word width
- ADDR_WIDTH, 5, memory address width; must satisfy BASE_ADDR + FRAME_W*FRAME_H <= 2**ADDR_WIDTH
- FRAME_W, 8, pixels per line (>=1)
- FRAME_H, 4, lines per frame (>=1)
- BASE_ADDR, 0, memory address of pixel (0,0)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  begin one frame scan; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  single-cycle pulse when the last pixel is accepted downstream
- mem_rd_en  out  1  read strobe to frame memory
- mem_rd_addr  out  ADDR_WIDTH  read address to frame memory
- mem_rd_data  in  DATA_WIDTH  memory read data, valid 1 cycle after mem_rd_en
- pix_data  out  DATA_WIDTH  pixel output
- pix_valid  out  1  pix_data and flags valid
- pix_ready  in  1  downstream accepts when pix_valid && pix_ready at rising edge
- pix_sof / pix_eof  out  1 each  first / last pixel of frame, qualified by pix_valid
- pix_sol / pix_eol  out  1 each  first / last pixel of line, qualified by pix_valid

Behaviour:
- Reset (async, reset=0): state IDLE; x, y, inflight and FIFO cleared. Outputs busy, done, mem_rd_en, pix_valid and all flags = 0; mem_rd_addr = BASE_ADDR; pix_data = 0. Reset mid-frame aborts immediately: no done, FIFO contents discarded.
- States and transitions:
  - IDLE: start=1 at edge -> SCAN.
  - SCAN: issues reads; after the read of pixel (FRAME_W-1, FRAME_H-1) is issued -> DRAIN.
  - DRAIN: last pixel accepted -> IDLE with done=1 for that one cycle and busy=0 in the same cycle.
  - start while busy is ignored.
- Read issue rule (SCAN only): mem_rd_en = (fifo_count + inflight - pop) < 2, where pop = pix_valid && pix_ready and inflight is 0/1 (read issued last cycle).
  - mem_rd_en is combinational; mem_rd_addr is registered and advances by 1 on each issued read.
  - x wraps FRAME_W-1 -> 0 and increments y.
- Data capture: the cycle after an issued read, mem_rd_data is written into the FIFO. The FIFO output is registered.
- Latency: start sampled at edge N -> mem_rd_en=1 with addr BASE_ADDR in cycle N+1 -> pix_valid=1 in cycle N+3.
- Throughput: 1 pixel/cycle while pix_ready=1. Frame of W*H pixels completes with done at cycle N+3+W*H-1 when pix_ready is held high.
- Backpressure: while pix_valid && !pix_ready, pix_data and all flags hold stable; FIFO never overflows (guaranteed by the issue rule).
- Flags travel with data through the FIFO (stored alongside each entry):
  - sof = (x==0 && y==0)
  - eof = (x==W-1 && y==H-1)
  - sol = (x==0)
  - eol = (x==W-1)
  - W=1: sol and eol both set on every pixel.
- Arithmetic: address counter is ADDR_WIDTH bits, modulo 2**ADDR_WIDTH; x/y counters are $clog2 sized (min 1 bit).
- Simultaneous start and done in the same cycle: start is ignored (state is not IDLE when sampled).

Optional Feature:
- Macro FB_SCAN_RD_CONT_EN.
- Defined: continuous mode. On the last read issue, x/y and the address reload to 0/BASE_ADDR and the block stays in SCAN with no bubble. done still pulses as each frame's eof pixel is accepted; busy stays high; start is only needed once after reset.
- Undefined: single-frame mode as described above.

Decomposition:
- Package fb_pkg: state enum {IDLE, SCAN, DRAIN}; constant FIFO_DEPTH=2; pixel-flag struct {sof, eof, sol, eol}.
- One sub-module, fb_skid_fifo: 2-entry registered FIFO, width DATA_WIDTH+4, with push/pop/count/empty/full.

Test Plan (W=4, H=2, BASE_ADDR=4, memory preloaded addr a = 16'h0100+a):
1. Reset held low 3 cycles, then released -> all outputs 0 and mem_rd_addr=4; no activity without start.
2. start pulse at edge N, pix_ready=1 -> mem_rd_en cycles N+1..N+8, addrs 4..11; pixels 0104..010B in cycles N+3..N+10; sof on 0104, eol on 0107 and 010B, sol on 0108, eof on 010B; done=1 only in cycle N+10.
3. pix_ready toggled 1,0,0,1 repeatedly -> every value 0104..010B delivered exactly once in order; pix_data stable while stalled; mem_rd_en never asserted when FIFO+inflight=2.
4. start re-pulsed mid-frame -> ignored, sequence unchanged, exactly one done.
5. reset asserted while pixel 0106 is valid -> outputs 0 asynchronously; a new start restarts at addr 4 with sof.
6. FB_SCAN_RD_CONT_EN defined, one start, pix_ready=1 -> 0104..010B repeats back-to-back with no gap, done pulse every 8 cycles, busy constantly 1.
